// File: rtl/rvm_mem_arb_if.sv
// Bundled signals of the memory-port arbiter: per-port requester handshakes,
// shared response bus and the single core memory bus.
interface rvm_mem_arb_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int BW = DW / 8;

  logic [NPORTS-1:0]    req_valid;
  logic [NPORTS-1:0]    req_ready;
  logic [NPORTS*AW-1:0] req_addr;
  logic [NPORTS*DW-1:0] req_wdata;
  logic [NPORTS-1:0]    req_wen;
  logic [NPORTS*BW-1:0] req_b_en;

  logic [NPORTS-1:0]    rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_error;

  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_rdata;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_c_en;
  logic                 mem_w_en;
  logic [BW-1:0]        mem_b_en;
  logic                 mem_error;
  logic                 mem_stall;

  // The arbiter side: serves the requesters and drives the memory bus.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, req_b_en,
    input  mem_rdata, mem_error, mem_stall,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en
  );

  // The environment side: requesters plus the memory itself.
  modport master (
    output req_valid, req_addr, req_wdata, req_wen, req_b_en,
    output mem_rdata, mem_error, mem_stall,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  mem_addr, mem_wdata, mem_c_en, mem_w_en, mem_b_en
  );
endinterface

// File: rtl/rvm_mem_arb.sv
// Memory-port arbiter: multiplexes NPORTS valid/ready requesters onto the core's
// single memory bus, with round-robin or fixed priority and a stall timeout.
module rvm_mem_arb #(
  parameter int NPORTS    = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input logic          clk,
  input logic          reset,
  rvm_mem_arb_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] last_grant;
  logic [PW-1:0] cur_port;
  logic [CW-1:0] stall_cnt;

  logic          timeout_hit;
  logic          complete;
  logic          arb_cycle;
  logic          grant_any;
  logic [PW-1:0] grant_idx;

  // i-th candidate of the search: rotating from last_grant+1, or plain index order.
  function automatic logic [PW-1:0] scan_port(input int i, input logic [PW-1:0] last);
    int idx;
    if (PRIO_MODE != 0) idx = i;
    else                idx = (int'(last) + 1 + i) % NPORTS;
    return PW'(idx);
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && bus.mem_stall &&
                       (stall_cnt == CW'(TIMEOUT));
  assign complete    = (state == BUSY) && (!bus.mem_stall || timeout_hit);
  assign arb_cycle   = !reset && ((state == IDLE) || complete);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!grant_any && bus.req_valid[scan_port(i, last_grant)]) begin
        grant_any = 1'b1;
        grant_idx = scan_port(i, last_grant);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (arb_cycle && grant_any) bus.req_ready[grant_idx] = 1'b1;
  end

  // Pointer starts at NPORTS-1 so that the first round-robin search lands on port 0.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state         <= IDLE;
      last_grant    <= PW'(NPORTS - 1);
      cur_port      <= '0;
      stall_cnt     <= '0;
      bus.mem_c_en  <= 1'b0;
      bus.mem_w_en  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_b_en  <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      bus.rsp_valid <= complete ? (NPORTS'(1) << cur_port) : '0;
      if (complete) begin
        bus.rsp_rdata <= timeout_hit ? '0 : bus.mem_rdata;
        bus.rsp_error <= timeout_hit | bus.mem_error;
      end

      if (arb_cycle && grant_any) begin
        state         <= BUSY;
        cur_port      <= grant_idx;
        last_grant    <= grant_idx;
        stall_cnt     <= '0;
        bus.mem_c_en  <= 1'b1;
        bus.mem_w_en  <= bus.req_wen[grant_idx];
        bus.mem_addr  <= bus.req_addr[grant_idx*AW +: AW];
        bus.mem_wdata <= bus.req_wdata[grant_idx*DW +: DW];
        bus.mem_b_en  <= bus.req_b_en[grant_idx*BW +: BW];
      end else if (complete) begin
        // Address, data and enables keep their last values while idle.
        state        <= IDLE;
        bus.mem_c_en <= 1'b0;
      end else if (state == BUSY) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/rvm_mem_arb.md
# rvm_mem_arb

Parametrised memory-port arbiter for the RISC-V multi-cycle core. It multiplexes NPORTS requesters onto the core's single memory bus (mem_addr, mem_rdata, mem_wdata, mem_c_en, mem_b_en, mem_error, mem_stall). Typical requesters are the instruction fetch path, the load/store path and a debug port. It adds per-port valid/ready handshakes, round-robin or fixed-priority arbitration, registered responses and a stall timeout, none of which the single-port core bus has.

## Interface
- NPORTS, 2, number of requester ports (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8); BW = DW/8.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).
- TIMEOUT, 255, consecutive stalled cycles before abort; 0 disables the timeout.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NPORTS  per-port request valid.
- req_ready  out  NPORTS  per-port accept; one-hot or zero.
- req_addr  in  NPORTS*AW  per-port address; port p occupies bits [p*AW +: AW].
- req_wdata  in  NPORTS*DW  per-port write data.
- req_wen  in  NPORTS  per-port write (1) / read (0).
- req_b_en  in  NPORTS*BW  per-port byte enables.
- rsp_valid  out  NPORTS  one-cycle response pulse, one-hot.
- rsp_rdata  out  DW  response read data, shared by all ports.
- rsp_error  out  1  response error, qualified by rsp_valid.
- mem_addr  out  AW  memory address.
- mem_rdata  in  DW  memory read data.
- mem_wdata  out  DW  memory write data.
- mem_c_en  out  1  memory chip enable.
- mem_w_en  out  1  memory write enable.
- mem_b_en  out  BW  memory byte enables.
- mem_error  in  1  memory error; sampled at completion.
- mem_stall  in  1  memory stall; holds the current access.

## Operation
- FSM has two states, IDLE and BUSY. Reset forces IDLE.
- Arbitration cycle: any cycle in IDLE, or the completion cycle in BUSY.
  - If any req_valid is set, choose grant g and assert req_ready[g] combinationally.
  - Latch port g's addr, wdata, wen and b_en into the mem_* output registers. Next state is BUSY.
  - If no request is pending, next state is IDLE.
- Round-robin: search starts at last_grant+1, modulo NPORTS. last_grant updates only on a grant. Its reset value is NPORTS-1, so port 0 wins first.
- Fixed priority: lowest-index valid port wins. The pointer is ignored.
- Requester rule: hold req_valid and payload stable until req_ready. Withdrawing a request before ready is illegal.
- BUSY: mem_c_en=1 with the latched fields stable.
  - A cycle with mem_stall=0 is the completion cycle.
  - At completion, capture mem_rdata into rsp_rdata and mem_error into rsp_error; writes capture rdata as well.
  - At completion, pulse rsp_valid[g] in the following cycle.
- Stall counter: clears on entering BUSY and increments on each stalled cycle.
  - When TIMEOUT!=0 and the count reaches TIMEOUT, abort: treat the cycle as completion with rsp_error=1 and rsp_rdata=0.
  - At abort, drop mem_c_en unless a new grant is made in the same cycle.
- mem_c_en=0 in IDLE. mem_addr, mem_wdata, mem_w_en and mem_b_en hold their last values.
- Synchronous reset mid-access: the access is abandoned and no rsp_valid is issued for it. The pointer and counter reinitialise.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_c_en=0, mem_w_en=0, mem_addr=0, mem_wdata=0, mem_b_en=0.
- Accept at cycle T. mem_c_en rises at T+1. With zero stall, completion is T+1 and rsp_valid is at T+2. Each stalled cycle adds one cycle.
- Back-to-back: a new accept is allowed in the completion cycle. This gives one access per cycle with no idle bubble.
- rsp_valid of an earlier access may coincide with req_ready of a later one, on the same or a different port.
- req_ready depends combinationally on req_valid, state and mem_stall. It carries no combinational path from mem_rdata or mem_error.
- Timeout abort fires in the cycle where the stalled-cycle count equals TIMEOUT. The response follows one cycle later.

## Test plan
- Single port 0 read, addr 0x100, no stall, mem_rdata=0xDEADBEEF:
  - req_ready[0] at T, mem_c_en at T+1 with mem_addr=0x100 and mem_w_en=0, rsp_valid[0] at T+2 with rsp_rdata=0xDEADBEEF and rsp_error=0.
- Round-robin, NPORTS=3, all ports requesting continuously:
  - Grants in order 0,1,2,0,1,2, with one access per cycle and no bubble.
- PRIO_MODE=1, ports 0 and 2 requesting continuously:
  - Port 0 is granted every time and port 2 is never granted while port 0 holds valid.
- Port 1 write, wdata=0x12345678, b_en=0x3, mem_stall high for 3 cycles:
  - mem_c_en, mem_w_en, mem_wdata and mem_b_en are stable for 4 cycles, then rsp_valid[1] follows.
- TIMEOUT=4 with mem_stall held high:
  - Abort after 4 stalled cycles; rsp_valid pulses with rsp_error=1 and rsp_rdata=0; mem_c_en falls.
- reset asserted in the cycle after an accept:
  - All outputs return to their reset values at the next edge, no rsp_valid is issued, and the next grant goes to port 0.
